// File: rtl/fifo_stream_pkg.sv
// Shared defaults, width helpers and pointer/occupancy types for the FIFO read-side
// stream adapter.
package fifo_stream_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned DEF_BUF_DEPTH  = 3;
    localparam int unsigned DEF_RD_LATENCY = 1;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    typedef logic [ptr_width(DEF_BUF_DEPTH)-1:0] buf_ptr_t;
    typedef logic [occ_width(DEF_BUF_DEPTH)-1:0] buf_occ_t;

endpackage

// File: rtl/stream_prefetch_buffer.sv
// Circular prefetch store for the read stream adapter: head/tail/occupancy with
// push, pop and a synchronous clear that wins over a same-cycle push.
module stream_prefetch_buffer
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    localparam int unsigned PTR_W     = ptr_width(BUF_DEPTH),
    localparam int unsigned OCC_W     = occ_width(BUF_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_data_o,
    output logic [OCC_W-1:0]      occ_o,
    output logic                  valid_o
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 32'd1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      head_d;
    logic [PTR_W-1:0]      tail_q;
    logic [PTR_W-1:0]      tail_d;
    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic                  push_s;
    logic                  pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Qualify requests: pop needs a word, push needs a slot or a simultaneous pop.
    always_comb begin
        pop_s  = pop_i && (occ_q != {OCC_W{1'b0}});
        push_s = push_i && ((occ_q != FULL_OCC) || pop_s);
    end

    // Pointer and occupancy next-state; clear discards everything held.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear_i) begin
            head_d = {PTR_W{1'b0}};
            tail_d = {PTR_W{1'b0}};
            occ_d  = {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_d = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            occ_d = occ_q + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            occ_q  <= {OCC_W{1'b0}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage write at the tail; cleared on reset so the head reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s && !clear_i) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[head_q];
    assign occ_o       = occ_q;
    assign valid_o     = (occ_q != {OCC_W{1'b0}});

endmodule

// File: rtl/fifo_read_stream_adapter.sv
// Drains the async FIFO read port into a valid/ready stream, using read credits and
// an in-flight pipe so the FIFO read latency is hidden behind a prefetch buffer.
module fifo_read_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  empty,
    output logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam int unsigned OCC_W = occ_width(BUF_DEPTH);
    localparam int unsigned CRD_W = occ_width(BUF_DEPTH + RD_LATENCY);
    localparam int unsigned LAST  = RD_LATENCY - 32'd1;

    logic [RD_LATENCY-1:0] pipe_vld_q;
    logic [RD_LATENCY-1:0] pipe_vld_d;
    logic [RD_LATENCY-1:0] pipe_kill_q;
    logic [RD_LATENCY-1:0] pipe_kill_d;
    logic [CRD_W-1:0]      inflight_s;
    logic [CRD_W-1:0]      credit_used_s;
    logic [OCC_W-1:0]      occ_s;
    logic                  buf_valid_s;
    logic                  r_en_s;
    logic                  land_s;
    logic                  land_drop_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CNT_WIDTH-1:0]  word_count_q;
    logic [CNT_WIDTH-1:0]  word_count_d;
    logic [CNT_WIDTH-1:0]  drop_count_q;
    logic [CNT_WIDTH-1:0]  drop_count_d;
    logic [CNT_WIDTH-1:0]  drop_inc_s;

    // Count reads issued whose data has not yet landed.
    always_comb begin
        inflight_s = {CRD_W{1'b0}};
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight_s = inflight_s + CRD_W'(pipe_vld_q[i]);
        end
    end

    // Read only when the word is guaranteed a buffer slot; m_ready deliberately absent.
    always_comb begin
        credit_used_s = CRD_W'(occ_s) + inflight_s;
        r_en_s        = !empty && !flush && (credit_used_s < CRD_W'(BUF_DEPTH));
    end

    // Advance the in-flight pipe; a flush marks every word still travelling for discard.
    always_comb begin
        pipe_vld_d     = pipe_vld_q;
        pipe_kill_d    = pipe_kill_q;
        pipe_vld_d[0]  = r_en_s;
        pipe_kill_d[0] = 1'b0;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_kill_d[i] = pipe_vld_q[i-1] && (pipe_kill_q[i-1] || flush);
        end
    end

    // Landing word is kept unless flushed now or tagged by an earlier flush.
    always_comb begin
        land_s      = pipe_vld_q[LAST];
        land_drop_s = land_s && (pipe_kill_q[LAST] || flush);
        push_s      = land_s && !land_drop_s;
        pop_s       = buf_valid_s && m_ready;
    end

    // Transfer and discard counters; a pop during flush counts as delivered, not dropped.
    always_comb begin
        word_count_d = word_count_q + CNT_WIDTH'(pop_s);
        if (flush) begin
            drop_inc_s = CNT_WIDTH'(occ_s) - CNT_WIDTH'(pop_s) + CNT_WIDTH'(land_drop_s);
        end else begin
            drop_inc_s = CNT_WIDTH'(land_drop_s);
        end
        drop_count_d = drop_count_q + drop_inc_s;
    end

    // Pipe and counter registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pipe_vld_q   <= {RD_LATENCY{1'b0}};
            pipe_kill_q  <= {RD_LATENCY{1'b0}};
            word_count_q <= {CNT_WIDTH{1'b0}};
            drop_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            pipe_vld_q   <= pipe_vld_d;
            pipe_kill_q  <= pipe_kill_d;
            word_count_q <= word_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    stream_prefetch_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk_i       (rclk),
        .rst_ni      (rrst_n),
        .clear_i     (flush),
        .push_i      (push_s),
        .push_data_i (data_out),
        .pop_i       (pop_s),
        .head_data_o (m_data),
        .occ_o       (occ_s),
        .valid_o     (buf_valid_s)
    );

    assign r_en       = r_en_s;
    assign m_valid    = buf_valid_s;
    assign word_count = word_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Directed bench for fifo_read_stream_adapter with a one-cycle-latency FIFO read model.
module tb_fifo_read_stream_adapter;
    import fifo_stream_pkg::*;

    logic        rclk;
    logic        rrst_n;
    logic        empty;
    logic        r_en;
    logic [7:0]  data_out;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        flush;
    logic [15:0] word_count;
    logic [15:0] drop_count;

    logic [7:0]  fmem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          ren_cnt = 0;
    logic [7:0]  got [$];
    int          compared = 0;
    int          mismatched = 0;
    int          exp_wc = 0;
    int          exp_dc = 0;

    fifo_read_stream_adapter #(
        .DATA_WIDTH (8),
        .RD_LATENCY (1),
        .BUF_DEPTH  (3),
        .CNT_WIDTH  (16)
    ) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .empty      (empty),
        .r_en       (r_en),
        .data_out   (data_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .word_count (word_count),
        .drop_count (drop_count)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    assign empty = (rd_ptr == wr_ptr);

    // FIFO read port: registered data one cycle after an accepted r_en; reset empties it.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_ptr   <= wr_ptr;
            data_out <= 8'h00;
        end else if (r_en && !empty) begin
            data_out <= fmem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Count r_en pulses and record every stream transfer.
    always @(posedge rclk) begin
        if (r_en) ren_cnt <= ren_cnt + 1;
        if (rrst_n && m_valid && m_ready) got.push_back(m_data);
    end

    task automatic load_seq(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fmem[(wr_ptr + i) % 256] = first + 8'(i);
        wr_ptr = wr_ptr + n;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0; m_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        compared++; if (r_en !== 1'b0) begin mismatched++; $display("FAIL reset_r_en got %0b want 0", r_en); end
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
        compared++; if (m_data !== 8'h00) begin mismatched++; $display("FAIL reset_m_data got %h want 00", m_data); end
        compared++; if (word_count !== 16'd0) begin mismatched++; $display("FAIL reset_word_count got %0d want 0", word_count); end
        compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
        for (int c = 0; c < 20; c++) begin
            @(negedge rclk);
            compared++;
            if (r_en !== 1'b0 || m_valid !== 1'b0 || word_count !== 16'd0 || drop_count !== 16'd0) begin
                mismatched++;
                $display("FAIL idle_cycle%0d got r_en=%0b m_valid=%0b wc=%0d dc=%0d want all 0", c, r_en, m_valid, word_count, drop_count);
            end
        end
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        load_seq(8'h01, 8);
        @(negedge rclk);
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL stream_latency got m_valid=%0b want 0", m_valid); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge rclk);
            compared++;
            if (m_valid !== 1'b1 || m_data !== 8'(k)) begin
                mismatched++;
                $display("FAIL stream_word%0d got v=%0b d=%h want v=1 d=%h", k, m_valid, m_data, 8'(k));
            end
        end
        @(negedge rclk);
        exp_wc += 8;
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drained got m_valid=%0b want 0", m_valid); end
        compared++; if (word_count !== 16'(exp_wc)) begin mismatched++; $display("FAIL stream_word_count got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_backpressure();
        int base;
        int start;
        buf_occ_t occ_seen;
        m_ready = 1'b0;
        base = ren_cnt;
        start = got.size();
        load_seq(8'h01, 8);
        repeat (10) @(negedge rclk);
        occ_seen = dut.u_buf.occ_o;
        compared++; if (ren_cnt - base !== 3) begin mismatched++; $display("FAIL bp_reads got %0d want 3", ren_cnt - base); end
        compared++; if (r_en !== 1'b0) begin mismatched++; $display("FAIL bp_r_en got %0b want 0", r_en); end
        compared++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin mismatched++; $display("FAIL bp_hold got v=%0b d=%h want v=1 d=01", m_valid, m_data); end
        compared++; if (occ_seen !== 2'd3) begin mismatched++; $display("FAIL bp_occ got %0d want 3", occ_seen); end
        m_ready = 1'b1;
        for (int i = 0; i < 60 && got.size() < start + 8; i++) @(negedge rclk);
        repeat (4) @(negedge rclk);
        compared++; if (got.size() !== start + 8) begin mismatched++; $display("FAIL bp_count got %0d want %0d", got.size() - start, 8); end
        for (int k = 0; k < 8 && start + k < got.size(); k++) begin
            compared++;
            if (got[start + k] !== 8'(k + 1)) begin
                mismatched++;
                $display("FAIL bp_word%0d got %h want %h", k, got[start + k], 8'(k + 1));
            end
        end
        exp_wc += 8;
        compared++; if (word_count !== 16'(exp_wc)) begin mismatched++; $display("FAIL bp_word_count got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_toggle();
        int start;
        start = got.size();
        m_ready = 1'b1;
        load_seq(8'hA0, 16);
        for (int i = 0; i < 200 && got.size() < start + 16; i++) begin
            @(negedge rclk);
            m_ready = ~m_ready;
        end
        m_ready = 1'b1;
        repeat (4) @(negedge rclk);
        compared++; if (got.size() !== start + 16) begin mismatched++; $display("FAIL toggle_count got %0d want 16", got.size() - start); end
        for (int k = 0; k < 16 && start + k < got.size(); k++) begin
            compared++;
            if (got[start + k] !== 8'hA0 + 8'(k)) begin
                mismatched++;
                $display("FAIL toggle_word%0d got %h want %h", k, got[start + k], 8'hA0 + 8'(k));
            end
        end
        exp_wc += 16;
        compared++; if (word_count !== 16'(exp_wc)) begin mismatched++; $display("FAIL toggle_word_count got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_flush();
        int start;
        buf_occ_t occ_seen;
        m_ready = 1'b0;
        start = got.size();
        load_seq(8'h11, 5);
        repeat (3) @(negedge rclk);
        occ_seen = dut.u_buf.occ_o;
        compared++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin mismatched++; $display("FAIL flush_pre got v=%0b d=%h want v=1 d=11", m_valid, m_data); end
        compared++; if (occ_seen !== 2'd2) begin mismatched++; $display("FAIL flush_pre_occ got %0d want 2", occ_seen); end
        flush = 1'b1;
        #1;
        compared++; if (r_en !== 1'b0) begin mismatched++; $display("FAIL flush_r_en got %0b want 0", r_en); end
        @(negedge rclk);
        flush = 1'b0;
        exp_dc += 3;
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL flush_m_valid got %0b want 0", m_valid); end
        compared++; if (drop_count !== 16'(exp_dc)) begin mismatched++; $display("FAIL flush_drop_count got %0d want %0d", drop_count, exp_dc); end
        m_ready = 1'b1;
        for (int i = 0; i < 40 && got.size() < start + 2; i++) @(negedge rclk);
        repeat (4) @(negedge rclk);
        compared++; if (got.size() !== start + 2) begin mismatched++; $display("FAIL flush_resume_count got %0d want 2", got.size() - start); end
        if (got.size() >= start + 2) begin
            compared++; if (got[start] !== 8'h14) begin mismatched++; $display("FAIL flush_resume0 got %h want 14", got[start]); end
            compared++; if (got[start + 1] !== 8'h15) begin mismatched++; $display("FAIL flush_resume1 got %h want 15", got[start + 1]); end
        end
        exp_wc += 2;
        compared++; if (word_count !== 16'(exp_wc)) begin mismatched++; $display("FAIL flush_word_count got %0d want %0d", word_count, exp_wc); end
        compared++; if (drop_count !== 16'(exp_dc)) begin mismatched++; $display("FAIL flush_drop_stable got %0d want %0d", drop_count, exp_dc); end
    endtask

    task automatic test_single();
        int base;
        m_ready = 1'b1;
        base = ren_cnt;
        load_seq(8'h5A, 1);
        #1;
        compared++; if (r_en !== 1'b1) begin mismatched++; $display("FAIL single_r_en got %0b want 1", r_en); end
        @(negedge rclk);
        compared++; if (m_valid !== 1'b0 || r_en !== 1'b0) begin mismatched++; $display("FAIL single_gap got v=%0b r_en=%0b want 0 0", m_valid, r_en); end
        @(negedge rclk);
        compared++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin mismatched++; $display("FAIL single_word got v=%0b d=%h want v=1 d=5a", m_valid, m_data); end
        @(negedge rclk);
        exp_wc += 1;
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL single_after got m_valid=%0b want 0", m_valid); end
        compared++; if (ren_cnt - base !== 1) begin mismatched++; $display("FAIL single_reads got %0d want 1", ren_cnt - base); end
        compared++; if (word_count !== 16'(exp_wc)) begin mismatched++; $display("FAIL single_word_count got %0d want %0d", word_count, exp_wc); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        load_seq(8'h30, 8);
        repeat (4) @(negedge rclk);
        compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL midrst_pre got m_valid=%0b want 1", m_valid); end
        #2;
        rrst_n = 1'b0;
        #1;
        compared++; if (r_en !== 1'b0) begin mismatched++; $display("FAIL midrst_r_en got %0b want 0", r_en); end
        compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_m_valid got %0b want 0", m_valid); end
        compared++; if (m_data !== 8'h00) begin mismatched++; $display("FAIL midrst_m_data got %h want 00", m_data); end
        compared++; if (word_count !== 16'd0) begin mismatched++; $display("FAIL midrst_word_count got %0d want 0", word_count); end
        compared++; if (drop_count !== 16'd0) begin mismatched++; $display("FAIL midrst_drop_count got %0d want 0", drop_count); end
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_wc = 0;
        exp_dc = 0;
        repeat (3) @(negedge rclk);
        compared++; if (m_valid !== 1'b0 || word_count !== 16'd0) begin mismatched++; $display("FAIL midrst_after got v=%0b wc=%0d want 0 0", m_valid, word_count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_single();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
